// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: state register, wait/timeout tracking
// and retire counter, with all datapath controls decoded combinationally.
module mc_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_en,
    output logic        reg_write,
    output logic        wd_sel,
    output logic        reg_dst,
    output logic        ext_op,
    output logic [1:0]  alu_srca,
    output logic [1:0]  alu_srcb,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] instr_cnt
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IMMEX  = 4'd10, S_IMMWB = 4'd11,
        S_ERROR  = 4'd15
    } state_t;

    localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_J   = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101, OP_LUI = 6'b001111;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100, ALU_SLL = 3'b101, ALU_SRL = 3'b110, ALU_PASSA = 3'b111;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;
    logic          req_c, we_c, irw_c, pce_c, rw_c;
    logic          retire;
    logic          rt_legal, rt_shift;
    logic [2:0]    rt_alu;

    always_comb begin
        rt_legal = 1'b1;
        rt_shift = 1'b0;
        rt_alu   = ALU_ADD;
        case (funct)
            6'b100000: rt_alu = ALU_ADD;
            6'b100010: rt_alu = ALU_SUB;
            6'b100100: rt_alu = ALU_AND;
            6'b100101: rt_alu = ALU_OR;
            6'b101010: rt_alu = ALU_SLT;
            6'b000000: begin rt_alu = ALU_SLL; rt_shift = 1'b1; end
            6'b000010: begin rt_alu = ALU_SRL; rt_shift = 1'b1; end
            default:   rt_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retire    = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        irw_c     = 1'b0;
        pce_c     = 1'b0;
        rw_c      = 1'b0;
        iord      = 1'b0;
        wd_sel    = 1'b0;
        reg_dst   = 1'b0;
        ext_op    = 1'b0;
        alu_srca  = 2'b00;
        alu_srcb  = 2'b00;
        alu_op    = ALU_ADD;
        pc_src    = 2'b00;
        case (state_q)
            S_FETCH: begin
                req_c    = 1'b1;
                alu_srca = 2'b10;
                alu_srcb = 2'b01;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pce_c   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                alu_srca = 2'b10;
                alu_srcb = 2'b11;
                ext_op   = 1'b1;
                case (op)
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_RTYPE:               state_d = rt_legal ? S_EXEC : S_ERROR;
                    OP_BEQ:                 state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMMEX;
                    default:                state_d = S_ERROR;
                endcase
                illegal_d = illegal_q | (state_d == S_ERROR);
            end
            S_MEMADR: begin
                alu_srcb = 2'b10;
                ext_op   = 1'b1;
                state_d  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                req_c = 1'b1;
                we_c  = (state_q == S_MEMWR);
                iord  = 1'b1;
                if (mem_ready) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                    retire  = (state_q == S_MEMWR);
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end
            end
            S_MEMWB: begin
                rw_c    = 1'b1;
                wd_sel  = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC: begin
                alu_srca = rt_shift ? 2'b01 : 2'b00;
                alu_op   = rt_alu;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c    = 1'b1;
                reg_dst = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                alu_op  = ALU_SUB;
                pc_src  = 2'b01;
                pce_c   = zero;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pce_c   = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_IMMEX: begin
                case (op)
                    OP_ORI: begin alu_srcb = 2'b10; alu_op = ALU_OR; end
                    OP_LUI: begin alu_srca = 2'b11; alu_op = ALU_PASSA; end
                    default: begin alu_srcb = 2'b10; ext_op = 1'b1; end
                endcase
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                rw_c    = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // Counter restarts whenever a new state is entered, so each memory wait is timed on its own.
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (!mem_ready && (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR))
            wait_d = wait_q + WW'(1);
        cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cnt_q     <= 32'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Enables are gated by reset so nothing reaches memory or the register file while held.
    assign mem_req   = req_c & rst;
    assign mem_we    = we_c & rst;
    assign ir_write  = irw_c & rst;
    assign pc_en     = pce_c & rst;
    assign reg_write = rw_c & rst;
    assign state     = state_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle expected control vectors are queued with the
// mem_ready stimulus for each instruction and compared as the FSM walks them.
module tb_mc_ctrl;
    logic        clk, rst;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_en, reg_write, wd_sel, reg_dst, ext_op;
    logic [1:0]  alu_srca, alu_srcb, pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        illegal, timeout;
    logic [31:0] instr_cnt;

    mc_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
        .reg_write(reg_write), .wd_sel(wd_sel), .reg_dst(reg_dst), .ext_op(ext_op),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .illegal(illegal), .timeout(timeout), .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, req, we, iord, irw, pce, rw, wds, rdst, srca, srcb, alu_op, pc_src, ext, illegal, timeout}
    logic [23:0] obs_vec;
    assign obs_vec = {state, mem_req, mem_we, iord, ir_write, pc_en, reg_write, wd_sel, reg_dst,
                      alu_srca, alu_srcb, alu_op, pc_src, ext_op, illegal, timeout};

    localparam logic [23:0] V_RST     = {4'd0,  8'b00000000, 2'b10, 2'b01, 3'd0, 2'd0, 1'b0, 2'b00};
    localparam logic [23:0] V_FETCH_W = {4'd0,  8'b10000000, 2'b10, 2'b01, 3'd0, 2'd0, 1'b0, 2'b00};
    localparam logic [23:0] V_FETCH_R = {4'd0,  8'b10011000, 2'b10, 2'b01, 3'd0, 2'd0, 1'b0, 2'b00};
    localparam logic [23:0] V_DEC     = {4'd1,  8'b00000000, 2'b10, 2'b11, 3'd0, 2'd0, 1'b1, 2'b00};
    localparam logic [23:0] V_MEMADR  = {4'd2,  8'b00000000, 2'b00, 2'b10, 3'd0, 2'd0, 1'b1, 2'b00};
    localparam logic [23:0] V_MEMRD   = {4'd3,  8'b10100000, 12'h000};
    localparam logic [23:0] V_MEMWB   = {4'd4,  8'b00000110, 12'h000};
    localparam logic [23:0] V_MEMWR   = {4'd5,  8'b11100000, 12'h000};
    localparam logic [23:0] V_ALUWB   = {4'd7,  8'b00000101, 12'h000};
    localparam logic [23:0] V_JUMP    = {4'd9,  8'b00001000, 2'b00, 2'b00, 3'd0, 2'b10, 1'b0, 2'b00};
    localparam logic [23:0] V_ADDI    = {4'd10, 8'b00000000, 2'b00, 2'b10, 3'b000, 2'd0, 1'b1, 2'b00};
    localparam logic [23:0] V_ORI     = {4'd10, 8'b00000000, 2'b00, 2'b10, 3'b011, 2'd0, 1'b0, 2'b00};
    localparam logic [23:0] V_LUI     = {4'd10, 8'b00000000, 2'b11, 2'b00, 3'b111, 2'd0, 1'b0, 2'b00};
    localparam logic [23:0] V_IMMWB   = {4'd11, 8'b00000100, 12'h000};
    localparam logic [23:0] V_ERR_I   = {4'd15, 8'b00000000, 10'd0, 2'b10};
    localparam logic [23:0] V_ERR_T   = {4'd15, 8'b00000000, 10'd0, 2'b01};

    logic [23:0] exp_q[$];
    logic        mr_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push(input logic mr, input logic [23:0] v);
        mr_q.push_back(mr);
        exp_q.push_back(v);
    endtask

    task automatic drain(input string tag);
        logic [23:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            mem_ready = mr_q.pop_front();
            #1;
            e = exp_q.pop_front();
            check(tag, {8'h00, obs_vec}, {8'h00, e});
        end
    endtask

    task automatic check_cnt(input string tag);
        @(posedge clk);
        #1;
        check(tag, instr_cnt, exp_cnt);
        check({tag, "_state"}, {28'h0, state}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(tag, {8'h00, obs_vec}, {8'h00, V_RST});
        check({tag, "_cnt"}, instr_cnt, 32'd0);
        exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic fetch_dec(input int waits);
        for (int i = 0; i < waits; i++) push(1'b0, V_FETCH_W);
        push(1'b1, V_FETCH_R);
        push(1'b1, V_DEC);
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] ao, input logic [1:0] sa,
                         input int waits, input string tag);
        op = 6'b000000;
        funct = f;
        fetch_dec(waits);
        push(1'b1, {4'd6, 8'h00, sa, 2'b00, ao, 2'b00, 1'b0, 2'b00});
        push(1'b1, V_ALUWB);
        drain(tag);
        exp_cnt++;
    endtask

    task automatic lw(input int low);
        op = 6'b100011;
        fetch_dec(0);
        push(1'b1, V_MEMADR);
        for (int i = 0; i < low; i++) push(1'b0, V_MEMRD);
        push(1'b1, V_MEMRD);
        push(1'b1, V_MEMWB);
        drain("lw");
        exp_cnt++;
    endtask

    task automatic beq(input logic z);
        op = 6'b000100;
        zero = z;
        fetch_dec(0);
        push(1'b1, {4'd8, (z ? 8'b00001000 : 8'b00000000), 2'b00, 2'b00, 3'b001, 2'b01, 1'b0, 2'b00});
        drain(z ? "beq_taken" : "beq_not_taken");
        exp_cnt++;
    endtask

    task automatic imm(input logic [5:0] o, input logic [23:0] v, input string tag);
        op = o;
        fetch_dec(0);
        push(1'b1, v);
        push(1'b1, V_IMMWB);
        drain(tag);
        exp_cnt++;
    endtask

    function automatic logic [10:0] rt_entry(input int i);
        case (i)
            0: return {6'b100000, 3'b000, 2'b00};
            1: return {6'b100010, 3'b001, 2'b00};
            2: return {6'b100100, 3'b010, 2'b00};
            3: return {6'b100101, 3'b011, 2'b00};
            4: return {6'b101010, 3'b100, 2'b00};
            5: return {6'b000000, 3'b101, 2'b01};
            default: return {6'b000010, 3'b110, 2'b01};
        endcase
    endfunction

    initial begin
        logic [10:0] ent;
        rst = 1'b0;
        mem_ready = 1'b0;
        op = 6'd0;
        funct = 6'd0;
        zero = 1'b0;

        do_reset("reset_init");

        rtype(6'b100000, 3'b000, 2'b00, 0, "add");
        check_cnt("add_cnt");

        lw(3);
        check_cnt("lw_cnt");

        beq(1'b0);
        beq(1'b1);
        op = 6'b000010;
        fetch_dec(0);
        push(1'b1, V_JUMP);
        drain("jump");
        exp_cnt++;
        imm(6'b001000, V_ADDI, "addi");
        imm(6'b001101, V_ORI, "ori");
        imm(6'b001111, V_LUI, "lui");
        op = 6'b101011;
        fetch_dec(1);
        push(1'b1, V_MEMADR);
        push(1'b0, V_MEMWR);
        push(1'b0, V_MEMWR);
        push(1'b1, V_MEMWR);
        drain("sw");
        exp_cnt++;
        check_cnt("mix_cnt");

        for (int k = 0; k < 8; k++) begin
            ent = rt_entry(int'($urandom_range(0, 6)));
            zero = 1'($urandom_range(0, 1));
            rtype(ent[10:5], ent[4:2], ent[1:0], int'($urandom_range(0, 4)), "rtype_rand");
        end
        check_cnt("rand_cnt");

        // Reset lands while sw is waiting on memory.
        op = 6'b101011;
        fetch_dec(0);
        push(1'b1, V_MEMADR);
        push(1'b0, V_MEMWR);
        push(1'b0, V_MEMWR);
        drain("sw_wait");
        do_reset("reset_memwr");
        rtype(6'b100101, 3'b011, 2'b00, 0, "or_after_reset");
        check_cnt("post_reset_cnt");

        op = 6'b111111;
        fetch_dec(0);
        push(1'b1, V_ERR_I);
        for (int i = 0; i < 20; i++) push(1'($urandom_range(0, 1)), V_ERR_I);
        drain("illegal_op");
        check("illegal_cnt", instr_cnt, exp_cnt);
        do_reset("reset_illegal");

        op = 6'b000000;
        funct = 6'b111111;
        fetch_dec(0);
        push(1'b1, V_ERR_I);
        push(1'b1, V_ERR_I);
        drain("illegal_funct");
        do_reset("reset_illfunct");

        for (int i = 0; i < 15; i++) push(1'b0, V_FETCH_W);
        push(1'b0, V_ERR_T);
        push(1'b1, V_ERR_T);
        drain("fetch_timeout");
        do_reset("reset_timeout");

        rtype(6'b100000, 3'b000, 2'b00, 14, "ready_on_15th");
        check_cnt("final_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15: the maximum number of consecutive mem_ready-low cycles tolerated in a memory state before a timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports op and funct, input, 6 bits each: instruction fields [31:26] and [5:0] from the instruction register.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag; port mem_ready, input, 1 bit: memory completion for the current request.
REQ-006 The block SHALL have outputs mem_req, mem_we, iord, ir_write, pc_en, reg_write, wd_sel, reg_dst, ext_op, 1 bit each, defined as follows:
- mem_req: memory request.
- mem_we: memory write.
- iord: 0 = PC, 1 = ALUOut as the memory address.
- ir_write: IR load.
- pc_en: PC load.
- reg_write: register file write.
- wd_sel: 0 = ALUOut, 1 = MDR.
- reg_dst: 0 = rt, 1 = rd.
- ext_op: 1 = sign extend, 0 = zero extend.
REQ-007 The block SHALL have outputs alu_srca and alu_srcb, 2 bits each:
- alu_srca: 00 = rs, 01 = shamt, 10 = PC, 11 = lui immediate.
- alu_srcb: 00 = rt, 01 = constant 4, 10 = imm32, 11 = imm32<<2.
REQ-008 The block SHALL have outputs alu_op, 3 bits, and pc_src, 2 bits:
- alu_op: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll, 110 srl, 111 pass-A.
- pc_src: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 The block SHALL have outputs state, 4 bits; illegal, 1 bit (sticky); timeout, 1 bit (sticky); instr_cnt, 32 bits (retired instructions).

Function
REQ-010 State encodings SHALL be:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
- EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IMMEX 10, IMMWB 11, ERROR 15
REQ-011 FETCH SHALL assert mem_req=1, iord=0, alu_srca=10, alu_srcb=01, alu_op=add, pc_src=00, and SHALL assert ir_write=1 and pc_en=1 only in the cycle where mem_ready=1; on that cycle the block SHALL go to DECODE, otherwise it SHALL stay in FETCH.
REQ-012 DECODE SHALL drive alu_srca=10, alu_srcb=11, alu_op=add, ext_op=1 (branch target into ALUOut), then branch on op:
- 100011 or 101011 -> MEMADR
- 000000 with a legal funct -> EXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000, 001101 or 001111 -> IMMEX
- anything else -> ERROR with illegal=1
REQ-013 Legal R-type funct values SHALL be: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010; sll and srl SHALL drive alu_srca=01, all others alu_srca=00; alu_srcb=00 for all.
REQ-014 MEMADR SHALL drive alu_srca=00, alu_srcb=10, add, ext_op=1, then go to MEMRD for lw or MEMWR for sw.
REQ-015 MEMRD SHALL drive mem_req=1 and iord=1, waiting for mem_ready, then go to MEMWB; MEMWB SHALL drive reg_write=1, wd_sel=1, reg_dst=0, then go to FETCH.
REQ-016 MEMWR SHALL drive mem_req=1, mem_we=1, iord=1, waiting for mem_ready, then go to FETCH.
REQ-017 ALUWB SHALL drive reg_write=1, wd_sel=0, reg_dst=1, then go to FETCH.
REQ-018 BRANCH SHALL drive alu_srca=00, alu_srcb=00, sub, pc_src=01, pc_en=zero, then go to FETCH.
REQ-019 JUMP SHALL drive pc_src=10, pc_en=1, then go to FETCH.
REQ-020 IMMEX SHALL drive, per opcode:
- addi: alu_srca=00, alu_srcb=10, add, ext_op=1
- ori: alu_srca=00, alu_srcb=10, or, ext_op=0
- lui: alu_srca=11, pass-A
REQ-021 IMMWB SHALL drive reg_write=1, reg_dst=0, wd_sel=0, then go to FETCH.
REQ-022 Outputs not named for a state SHALL be 0; all outputs SHALL be combinational from state, op, funct, zero and mem_ready (no extra latency).
REQ-023 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and SHALL increment each cycle spent there with mem_ready=0; when it reaches WAIT_MAX with mem_ready still 0, the next state SHALL be ERROR with timeout=1; mem_ready=1 on the WAIT_MAX cycle SHALL complete normally.
REQ-024 ERROR SHALL hold all enables at 0 and SHALL be left only by reset.
REQ-025 instr_cnt SHALL increment by 1, wrapping from 0xFFFFFFFF to 0, on every transition from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or IMMWB to FETCH.

Reset
REQ-026 While rst=0, the block SHALL drive state=FETCH, wait counter=0, instr_cnt=0, illegal=0, timeout=0, and force all 1-bit enables (mem_req, mem_we, ir_write, pc_en, reg_write) to 0, asynchronously.
REQ-027 On reset assertion mid-operation, including mid-wait, the block SHALL abandon the state immediately; after rst rises, the first edge SHALL evaluate FETCH.

Verification
REQ-028 The bench SHALL run add (op=0, funct=100000) with mem_ready=1 always and check FETCH->DECODE->EXEC->ALUWB->FETCH in 4 cycles, reg_write=1, reg_dst=1 in ALUWB, and instr_cnt=1.
REQ-029 The bench SHALL run lw with mem_ready held low 3 cycles in MEMRD and check the state stays 3 for 4 cycles, then MEMWB with wd_sel=1, giving 5+3=8 cycles total.
REQ-030 The bench SHALL run beq with zero=0 and check pc_en=0 in BRANCH; with zero=1 it SHALL check pc_en=1 and pc_src=01.
REQ-031 The bench SHALL apply op=111111 and check ERROR (state=15) and illegal=1, with mem_req staying 0 for 20 cycles until reset.
REQ-032 The bench SHALL hold mem_ready=0 in FETCH with WAIT_MAX=15 and check ERROR with timeout=1 after the 15th wait cycle; separately, mem_ready=1 on the 15th wait cycle SHALL reach DECODE.
REQ-033 The bench SHALL assert rst=0 mid-MEMWR and check immediate state=0, mem_we=0, instr_cnt=0, and normal fetch after release.
